// File: rtl/axi_dma_rd_burst.sv
// axi_dma_rd_burst: AXI4 read-burst master. A databus request issues a single
// fixed-length INCR AR burst. Each R beat is forwarded as rdata with a one-cycle
// ready strobe, and done pulses together with the ready of the last beat.
`ifndef DDR_ADDR_W
  `define DDR_ADDR_W 32
`endif
`ifndef MIG_BUS_W
  `define MIG_BUS_W 64
`endif
`ifndef AXI_ID_W
  `define AXI_ID_W 4
`endif
`ifndef AXI_LEN_W
  `define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
  `define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
  `define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
  `define AXI_RESP_W 2
`endif
`ifndef AXI_LOCK_W
  `define AXI_LOCK_W 1
`endif
`ifndef AXI_CACHE_W
  `define AXI_CACHE_W 4
`endif
`ifndef AXI_PROT_W
  `define AXI_PROT_W 3
`endif
`ifndef AXI_QOS_W
  `define AXI_QOS_W 4
`endif

module axi_dma_rd_burst #(
  parameter int BURST_LEN = 16,
  parameter bit USE_RAM   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [`DDR_ADDR_W-1:0]  addr,
  output logic                    ready,
  output logic [`MIG_BUS_W-1:0]   rdata,
  output logic                    done,
  output logic                    error,
  output logic [`AXI_ID_W-1:0]    m_axi_arid,
  output logic [`DDR_ADDR_W-1:0]  m_axi_araddr,
  output logic [`AXI_LEN_W-1:0]   m_axi_arlen,
  output logic [`AXI_SIZE_W-1:0]  m_axi_arsize,
  output logic [`AXI_BURST_W-1:0] m_axi_arburst,
  output logic [`AXI_LOCK_W-1:0]  m_axi_arlock,
  output logic [`AXI_CACHE_W-1:0] m_axi_arcache,
  output logic [`AXI_PROT_W-1:0]  m_axi_arprot,
  output logic [`AXI_QOS_W-1:0]   m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [`AXI_ID_W-1:0]    m_axi_rid,
  input  logic [`MIG_BUS_W-1:0]   m_axi_rdata,
  input  logic [`AXI_RESP_W-1:0]  m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int LEN_W  = `AXI_LEN_W;
  localparam int SIZE_W = `AXI_SIZE_W;
  localparam int RESP_W = `AXI_RESP_W;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [8:0] LAST_CNT = 9'(BURST_LEN - 1);

  logic [1:0] state;
  logic [8:0] cnt;
  logic       beat;
  logic       cnt_end;
  logic       last;

  // Beat ID is not used: only one AR is ever in flight.
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  assign m_axi_arid    = '0;
  assign m_axi_arlen   = LEN_W'(BURST_LEN - 1);
  assign m_axi_arsize  = SIZE_W'($clog2(`MIG_BUS_W / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = '0;
  assign m_axi_arcache = 4'h2;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = '0;

  assign beat    = (state == R_DATA) && m_axi_rvalid && m_axi_rready;
  assign cnt_end = (cnt == LAST_CNT);
  // Either the counter or the slave's RLAST ends the burst; disagreement is an error.
  assign last    = cnt_end || m_axi_rlast;

  // Burst control FSM: AR handshake, beat counting, error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= R_IDLE;
      cnt           <= '0;
      error         <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        R_IDLE: if (valid) begin
          m_axi_araddr  <= addr;
          m_axi_arvalid <= 1'b1;
          error         <= 1'b0;
          state         <= R_ADDR;
        end
        R_ADDR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          cnt           <= '0;
          state         <= R_DATA;
        end
        R_DATA: if (beat) begin
          cnt <= cnt + 9'd1;
          if (m_axi_rresp != RESP_W'(0) || (m_axi_rlast != cnt_end))
            error <= 1'b1;
          if (last) begin
            m_axi_rready <= 1'b0;
            state        <= R_DONE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  logic                  ready_q;
  logic                  done_q;
  logic [`MIG_BUS_W-1:0] rdata_q;

  // First output stage: capture each beat for the databus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= beat;
      done_q  <= beat && last;
      if (beat) rdata_q <= m_axi_rdata;
    end
  end

  generate
    if (USE_RAM) begin : g_lat1
      assign ready = ready_q;
      assign done  = done_q;
      assign rdata = rdata_q;
    end else begin : g_lat2
      logic                  ready_q2;
      logic                  done_q2;
      logic [`MIG_BUS_W-1:0] rdata_q2;
      // Second output stage for the two-cycle latency variant.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ready_q2 <= 1'b0;
          done_q2  <= 1'b0;
          rdata_q2 <= '0;
        end else begin
          ready_q2 <= ready_q;
          done_q2  <= done_q;
          rdata_q2 <= rdata_q;
        end
      end
      assign ready = ready_q2;
      assign done  = done_q2;
      assign rdata = rdata_q2;
    end
  endgenerate

endmodule

// File: tb/tb_axi_dma_rd_burst.sv
// Directed bench for axi_dma_rd_burst (BURST_LEN=16, USE_RAM=1).
`ifndef DDR_ADDR_W
  `define DDR_ADDR_W 32
`endif
`ifndef MIG_BUS_W
  `define MIG_BUS_W 64
`endif
`ifndef AXI_ID_W
  `define AXI_ID_W 4
`endif
`ifndef AXI_LEN_W
  `define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
  `define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
  `define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
  `define AXI_RESP_W 2
`endif
`ifndef AXI_LOCK_W
  `define AXI_LOCK_W 1
`endif
`ifndef AXI_CACHE_W
  `define AXI_CACHE_W 4
`endif
`ifndef AXI_PROT_W
  `define AXI_PROT_W 3
`endif
`ifndef AXI_QOS_W
  `define AXI_QOS_W 4
`endif

module tb_axi_dma_rd_burst;
  localparam int BL = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    valid = 1'b0;
  logic [`DDR_ADDR_W-1:0]  addr = '0;
  logic                    ready;
  logic [`MIG_BUS_W-1:0]   rdata;
  logic                    done;
  logic                    error;
  logic [`AXI_ID_W-1:0]    arid;
  logic [`DDR_ADDR_W-1:0]  araddr;
  logic [`AXI_LEN_W-1:0]   arlen;
  logic [`AXI_SIZE_W-1:0]  arsize;
  logic [`AXI_BURST_W-1:0] arburst;
  logic [`AXI_LOCK_W-1:0]  arlock;
  logic [`AXI_CACHE_W-1:0] arcache;
  logic [`AXI_PROT_W-1:0]  arprot;
  logic [`AXI_QOS_W-1:0]   arqos;
  logic                    arvalid;
  logic                    arready = 1'b0;
  logic [`AXI_ID_W-1:0]    rid = '0;
  logic [`MIG_BUS_W-1:0]   r_data = '0;
  logic [`AXI_RESP_W-1:0]  rresp = '0;
  logic                    rlast = 1'b0;
  logic                    rvalid = 1'b0;
  logic                    rready;

  int checks = 0;
  int fails  = 0;

  axi_dma_rd_burst #(.BURST_LEN(BL), .USE_RAM(1'b1)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr),
    .ready(ready), .rdata(rdata), .done(done), .error(error),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(r_data), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result of one burst as seen by the bench-side slave/requester.
  int n_ready, n_done, arv_cycles;
  bit order_ok, err_done, addr_stable, rready_early, rready_ok, err_launch;

  // Launch a burst and play an AXI slave. Inputs change and outputs are
  // sampled on falling edges. rst_beat>0 leaves the loop right after that
  // many beats have been delivered, with valid still held.
  task automatic run_burst(input logic [31:0] a, input int ar_delay, input bit gaps,
                           input int bad_beat, input int early_last, input int rst_beat);
    int  i, cyc, last_idx;
    bit  fire, par, fin;
    last_idx = (early_last >= 0) ? early_last : BL - 1;
    n_ready = 0; n_done = 0; arv_cycles = 0;
    order_ok = 1; err_done = 0; addr_stable = 1; rready_early = 0; rready_ok = 1;
    @(negedge clk); valid = 1'b1; addr = a;
    @(negedge clk);
    err_launch = error;
    for (int k = 0; k <= ar_delay; k++) begin
      if (arvalid) arv_cycles++;
      if (araddr !== a) addr_stable = 0;
      if (rready) rready_early = 1;
      if (k == ar_delay) arready = 1'b1;
      @(negedge clk);
    end
    arready = 1'b0;
    i = 0; cyc = 0; par = 1; fin = 0;
    while (!fin && cyc < 80) begin
      fire   = gaps ? par : 1'b1;
      par    = ~par;
      rvalid = fire;
      r_data = 64'(i);
      rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (i == last_idx);
      if (!rready) rready_ok = 0;
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (ready !== fire) order_ok = 0;
      if (fire && rdata !== 64'(i)) order_ok = 0;
      if (done !== (fire && i == last_idx)) order_ok = 0;
      if (ready) n_ready++;
      if (done) begin n_done++; err_done = error; fin = 1; end
      if (fire) i++;
      if (rst_beat > 0 && fire && i == rst_beat) fin = 1;
      cyc++;
    end
    if (rst_beat <= 0) valid = 1'b0;
  endtask

  initial begin
    // 1: reset values
    #2;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    @(negedge clk); rst = 1'b0;
    arv_cycles = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (arvalid) arv_cycles++; end
    check("idle_arvalid", 64'(arv_cycles), 64'd0);
    check("arlen", 64'(arlen), 64'd15);
    check("arsize", 64'(arsize), 64'd3);
    check("arburst", 64'(arburst), 64'd1);
    check("arcache", 64'(arcache), 64'h2);
    check("arprot", 64'(arprot), 64'h2);
    check("arid", 64'(arid), 64'd0);

    // 2: basic burst, immediate arready, continuous data
    run_burst(32'h1000, 0, 0, -1, -1, 0);
    check("b2_arvalid_cyc", 64'(arv_cycles), 64'd1);
    check("b2_araddr", 64'(addr_stable), 64'd1);
    check("b2_rready", 64'(rready_ok), 64'd1);
    check("b2_nready", 64'(n_ready), 64'd16);
    check("b2_order", 64'(order_ok), 64'd1);
    check("b2_ndone", 64'(n_done), 64'd1);
    check("b2_error", 64'(err_done), 64'd0);

    // 3: arready delayed 5 cycles
    run_burst(32'h2040, 5, 0, -1, -1, 0);
    check("b3_arvalid_cyc", 64'(arv_cycles), 64'd6);
    check("b3_addr_stable", 64'(addr_stable), 64'd1);
    check("b3_rready_early", 64'(rready_early), 64'd0);
    check("b3_nready", 64'(n_ready), 64'd16);
    check("b3_ndone", 64'(n_done), 64'd1);

    // 4: rvalid low every other cycle
    run_burst(32'h3000, 0, 1, -1, -1, 0);
    check("b4_order", 64'(order_ok), 64'd1);
    check("b4_nready", 64'(n_ready), 64'd16);
    check("b4_ndone", 64'(n_done), 64'd1);
    check("b4_error", 64'(err_done), 64'd0);

    // 5: bad RRESP on beat 7, then clean burst clears error at launch
    run_burst(32'h4000, 0, 0, 6, -1, 0);
    check("b5_error", 64'(err_done), 64'd1);
    check("b5_nready", 64'(n_ready), 64'd16);
    @(negedge clk);
    check("b5_error_hold", 64'(error), 64'd1);
    run_burst(32'h5000, 1, 0, -1, -1, 0);
    check("b5b_err_launch", 64'(err_launch), 64'd0);
    check("b5b_error", 64'(err_done), 64'd0);

    // 6: early RLAST on beat 3
    run_burst(32'h6000, 0, 0, -1, 2, 0);
    check("b6_nready", 64'(n_ready), 64'd3);
    check("b6_ndone", 64'(n_done), 64'd1);
    check("b6_order", 64'(order_ok), 64'd1);
    check("b6_error", 64'(err_done), 64'd1);
    @(negedge clk); @(negedge clk);
    check("b6_idle_arvalid", 64'(arvalid), 64'd0);
    check("b6_idle_rready", 64'(rready), 64'd0);

    // 6b: reset mid-burst after beat 5
    run_burst(32'h7000, 0, 0, -1, -1, 5);
    check("b7_nready", 64'(n_ready), 64'd5);
    check("b7_ready_pre", 64'(ready), 64'd1);
    rst = 1'b1;
    #1;
    check("b7_rst_ready", 64'(ready), 64'd0);
    check("b7_rst_rdata", 64'(rdata), 64'd0);
    check("b7_rst_rready", 64'(rready), 64'd0);
    check("b7_rst_araddr", 64'(araddr), 64'd0);
    check("b7_rst_arvalid", 64'(arvalid), 64'd0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_burst(32'h8000, 0, 0, -1, -1, 0);
    check("b8_recover", 64'(n_ready), 64'd16);
    check("b8_done", 64'(n_done), 64'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
